// File: rtl/skid_buffer_pkg.sv
// Shared elastic-pipeline definitions: state encoding for two-entry skid buffers
// and the mapping from state to held-word count.
package skid_buffer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occupancy_of(state_t s);
        case (s)
            EMPTY:   occupancy_of = 2'd0;
            BUSY:    occupancy_of = 2'd1;
            FULL:    occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_buffer_if.sv
// Upstream/downstream valid-ready handshake bundle for the skid buffer.
interface skid_buffer_if #(
    parameter int N = 32
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/skid_buffer_sync_reg.sv
// N-bit register with synchronous active-high clear and load enable.
module sync_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end
endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: in_ready depends only on registered state, so out_ready
// never reaches the upstream ready path combinationally.
//
//   state | meaning
//   EMPTY | no word held
//   BUSY  | main register holds the head word
//   FULL  | main holds head, skid holds the second word; upstream stalled
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        reset,
    skid_buffer_if.slave bus
);
    state_t       state_q;
    state_t       state_d;
    logic         in_rdy;
    logic         out_vld;
    logic         accept;
    logic         take;
    logic         main_load;
    logic         skid_load;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    assign accept = bus.in_valid && in_rdy;
    assign take   = out_vld && bus.out_ready;

    // Flush wins over any handshake; data registers may keep stale contents.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = bus.in_data;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = BUSY;
                        main_load = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && take) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_d   = BUSY;
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_rdy  = (state_q != FULL);
        out_vld = (state_q != EMPTY);
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.occupancy = occupancy_of(state_q);
    assign bus.out_data  = main_q;

    sync_reg #(.N(N)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    sync_reg #(.N(N)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (bus.in_data),
        .q     (skid_q)
    );
endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer against a queue-based reference model.
module tb_skid_buffer;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    skid_buffer_if #(.N(N)) bus ();

    skid_buffer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [N-1:0] mq[$];
    int           taken_cnt  = 0;
    int           pushed_cnt = 0;
    logic [N-1:0] last_taken;

    task automatic drive(input logic iv, input logic [N-1:0] d, input logic ordy,
                         input logic fl, input logic rs);
        reset         = rs;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    // Advance one clock and apply the same edge to the reference queue.
    task automatic tick();
        bit           acc;
        bit           tk;
        bit           rs;
        bit           fl;
        logic [N-1:0] d;
        acc = bus.in_valid && (mq.size() < 2);
        tk  = bus.out_ready && (mq.size() > 0);
        rs  = reset;
        fl  = bus.flush;
        d   = bus.in_data;
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (tk) begin
                last_taken = mq.pop_front();
                taken_cnt++;
            end
            if (acc) begin
                mq.push_back(d);
                pushed_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 ||
            bus.out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b occ=%0d data=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.occupancy, bus.out_data);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5_A5A5 || bus.occupancy !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_latency: got valid=%b data=%h occ=%0d, want 1 a5a5a5a5 1",
                     bus.out_valid, bus.out_data, bus.occupancy);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || last_taken !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL single_drain: got valid=%b occ=%0d, want 0 0", bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_fill_drain();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.occupancy !== 2'd2 || bus.out_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL fill_full: got in_ready=%b occ=%0d data=%h, want 0 2 11",
                     bus.in_ready, bus.occupancy, bus.out_data);
        end
        // Offered word while FULL must be ignored; head must hold steady while stalled.
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bus.out_data !== 32'h11 || bus.occupancy !== 2'd2) begin
            tests_failed++;
            $display("FAIL stall_stable: got data=%h occ=%0d, want 11 2", bus.out_data, bus.occupancy);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bus.out_data !== 32'h22 || bus.in_ready !== 1'b1 || bus.occupancy !== 2'd1) begin
            tests_failed++;
            $display("FAIL drain_second: got data=%h in_ready=%b occ=%0d, want 22 1 1",
                     bus.out_data, bus.in_ready, bus.occupancy);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || last_taken !== 32'h22) begin
            tests_failed++;
            $display("FAIL drain_empty: got valid=%b last=%h, want 0 22", bus.out_valid, last_taken);
        end
    endtask

    task automatic test_stream();
        int start_taken;
        int bad_ready;
        int bad_data;
        start_taken = taken_cnt;
        bad_ready   = 0;
        bad_data    = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, N'(i), 1'b1, 1'b0, 1'b0);
            if (bus.in_ready !== 1'b1) bad_ready++;
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== N'(i)) bad_data++;
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bad_ready != 0) begin
            tests_failed++;
            $display("FAIL stream_ready: got %0d cycles with in_ready low, want 0", bad_ready);
        end
        tests_run++;
        if (bad_data != 0) begin
            tests_failed++;
            $display("FAIL stream_order: got %0d wrong out words, want 0", bad_data);
        end
        tests_run++;
        if (taken_cnt - start_taken != 100 || last_taken !== 32'd99) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d words last=%0d, want 100 last=99",
                     taken_cnt - start_taken, last_taken);
        end
    endtask

    task automatic test_flush();
        int leaks;
        drive(1'b1, 32'hF1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hF2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: got occ=%0d valid=%b in_ready=%b, want 0 0 1",
                     bus.occupancy, bus.out_valid, bus.in_ready);
        end
        leaks = 0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) leaks++;
        end
        drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (leaks != 0 || bus.out_data !== 32'h77) begin
            tests_failed++;
            $display("FAIL flush_no_leak: got leaks=%0d data=%h, want 0 77", leaks, bus.out_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_full();
        drive(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC3, 1'b1, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 ||
            bus.out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_full: got in_ready=%b valid=%b occ=%0d data=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.occupancy, bus.out_data);
        end
        drive(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5A || bus.occupancy !== 2'd1) begin
            tests_failed++;
            $display("FAIL accept_after_reset: got valid=%b data=%h occ=%0d, want 1 5a 1",
                     bus.out_valid, bus.out_data, bus.occupancy);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        int errs;
        int start_push;
        int start_take;
        errs       = 0;
        start_push = pushed_cnt;
        start_take = taken_cnt;
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(1)), N'($urandom), 1'($urandom_range(1)), 1'b0, 1'b0);
            if (bus.in_ready !== (mq.size() < 2) || bus.out_valid !== (mq.size() > 0) ||
                bus.occupancy !== 2'(mq.size()) || bus.occupancy > 2'd2 ||
                (mq.size() > 0 && bus.out_data !== mq[0])) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_cycle %0d: got rdy=%b vld=%b occ=%0d data=%h, want occ=%0d",
                             c, bus.in_ready, bus.out_valid, bus.occupancy, bus.out_data, mq.size());
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL random_scoreboard: got %0d mismatching cycles, want 0", errs);
        end
        tests_run++;
        if (pushed_cnt - start_push != taken_cnt - start_take || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_conservation: got pushed=%0d taken=%0d valid=%b, want equal and 0",
                     pushed_cnt - start_push, taken_cnt - start_take, bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_stream();
        test_flush();
        test_reset_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
